lsu_bus_bridge: RTL and testbench

Load/store unit that sits directly downstream of the single-cycle core's data-memory port.
- Takes the core's combinational MemRead/MemWrite/m_addr/m_wr_dat/funct request.
- Converts it into a registered valid/ready word-addressed bus transaction with byte enables.
- Stalls the core until the transaction completes.
- Returns lane-aligned, sign- or zero-extended load data.
- Flags misaligned accesses and bus errors/timeouts.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_bus_bridge_lane_align.sv | 41 ++++
 rtl/lsu_bus_bridge.sv | 191 +++++++++++++++++++
 tb/tb_lsu_bus_bridge.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store bus bridge.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_bus_bridge_lane_align.sv
// Byte-lane formatting: store byte enables / replication, or load shift and extension.
import lsu_pkg::*;

module lsu_bus_bridge_lane_align (
    input  logic        load_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] data_i,
    output logic [3:0]  be_o,
    output logic [31:0] data_o
);

    logic [31:0] shifted_s;
    logic [31:0] st_s;
    logic [31:0] ld_s;

    // Lane selection and extension for the requested access size
    always_comb begin
        shifted_s = data_i >> {off_i, 3'b000};
        case (size_i)
            SZ_B: begin
                be_o = 4'b0001 << off_i;
                st_s = {4{data_i[7:0]}};
                ld_s = {{24{shifted_s[7] & ~uns_i}}, shifted_s[7:0]};
            end
            SZ_H: begin
                be_o = 4'b0011 << off_i;
                st_s = {2{data_i[15:0]}};
                ld_s = {{16{shifted_s[15] & ~uns_i}}, shifted_s[15:0]};
            end
            default: begin
                be_o = 4'b1111;
                st_s = data_i;
                ld_s = data_i;
            end
        endcase
        data_o = load_i ? ld_s : st_s;
    end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Bridges the core's combinational data-memory request onto a registered valid/ready bus,
// stalling the core until the transfer completes, errors or times out.
import lsu_pkg::*;

module lsu_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_funct,
    output logic                  stall,
    output logic [31:0]           rdata,
    output logic                  misalign_err,
    output logic                  access_err,
    output logic                  bus_valid,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wdata,
    output logic [3:0]            bus_be,
    input  logic                  bus_ready,
    input  logic [31:0]           bus_rdata,
    input  logic                  bus_err
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              be_q, be_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    mis_q, mis_d;
    logic                    acc_q, acc_d;
    logic [1:0]              off_q, off_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [1:0]              req_size_s;
    logic [3:0]              st_be_s;
    logic [31:0]             st_data_s;
    logic [3:0]              ld_be_unused_s;
    logic [31:0]             ld_data_s;
    logic                    stall_s;

    assign req_size_s = req_funct[1] ? SZ_W : req_funct[1:0];

    lsu_bus_bridge_lane_align u_store_align (
        .load_i (1'b0),
        .size_i (req_size_s),
        .off_i  (req_addr[1:0]),
        .uns_i  (req_funct[2]),
        .data_i (req_wdata),
        .be_o   (st_be_s),
        .data_o (st_data_s)
    );

    lsu_bus_bridge_lane_align u_load_align (
        .load_i (1'b1),
        .size_i (size_q),
        .off_i  (off_q),
        .uns_i  (uns_q),
        .data_i (bus_rdata),
        .be_o   (ld_be_unused_s),
        .data_o (ld_data_s)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        acc_d   = 1'b0;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        case (state_q)
            IDLE: begin
                if (req_read | req_write) begin
                    if (is_misaligned(req_size_s, req_addr[1:0])) begin
                        state_d = ERR;
                        mis_d   = 1'b1;
                        rdata_d = 32'h0000_0000;
                    end else begin
                        state_d = REQ;
                        valid_d = 1'b1;
                        we_d    = req_write & ~req_read;
                        addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        wdata_d = st_data_s;
                        be_d    = st_be_s;
                        off_d   = req_addr[1:0];
                        size_d  = req_size_s;
                        uns_d   = req_funct[2];
                        cnt_d   = {CNT_W{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus_ready & ~bus_err) begin
                    state_d = DONE;
                    valid_d = 1'b0;
                    rdata_d = we_q ? rdata_q : ld_data_s;
                end else if (bus_ready | (cnt_q == CNT_LAST)) begin
                    state_d = ERR;
                    valid_d = 1'b0;
                    acc_d   = 1'b1;
                    rdata_d = 32'h0000_0000;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q <= 32'h0000_0000;
            be_q    <= 4'b0000;
            rdata_q <= 32'h0000_0000;
            mis_q   <= 1'b0;
            acc_q   <= 1'b0;
            off_q   <= 2'b00;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            acc_q   <= acc_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
        end
    end

    // Core stall: held through acceptance and the bus wait, released in DONE/ERR
    always_comb begin
        if (!reset) begin
            stall_s = 1'b0;
        end else begin
            case (state_q)
                IDLE:    stall_s = req_read | req_write;
                REQ:     stall_s = 1'b1;
                default: stall_s = 1'b0;
            endcase
        end
    end

    assign stall        = stall_s;
    assign rdata        = rdata_q;
    assign misalign_err = mis_q;
    assign access_err   = acc_q;
    assign bus_valid    = valid_q;
    assign bus_we       = we_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign bus_be       = be_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Bench for lsu_bus_bridge: directed vector table, reset-abort sequence, randomized transactions.
module tb_lsu_bus_bridge;

    localparam int T = 4;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct;
        int          delay;
        logic        err;
        logic [31:0] rdat;
        logic [31:0] exp_rdata;
        int          exp_stall;
        logic        exp_mis;
        logic        exp_acc;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_funct = 3'b000;
    logic        stall;
    logic [31:0] rdata;
    logic        misalign_err;
    logic        access_err;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_err = 1'b0;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] last_rd = 32'h0;
    vec_t        vecs[14];

    lsu_bus_bridge #(.TIMEOUT_CYCLES(T), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct(req_funct),
        .stall(stall), .rdata(rdata), .misalign_err(misalign_err), .access_err(access_err),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: expectations from the access rules in plain arithmetic
    function automatic vec_t model(input vec_t v);
        int size, off;
        logic [31:0] lane, val;
        vec_t r = v;
        size = v.funct[1] ? 2 : int'(v.funct[1:0]);
        off  = int'(v.addr[1:0]);
        r.exp_mis = 1'b0;
        r.exp_acc = 1'b0;
        r.exp_be  = (size == 0) ? 4'(1 << off) : (size == 1) ? 4'(3 << off) : 4'hF;
        r.exp_wd  = (size == 0) ? v.wdata[7:0] * 32'h0101_0101 :
                    (size == 1) ? v.wdata[15:0] * 32'h0001_0001 : v.wdata;
        lane = v.rdat >> (8 * off);
        if (size == 0) begin
            val = lane % 32'h100;
            if (!v.funct[2] && val >= 32'h80) val = val - 32'h100;
        end else if (size == 1) begin
            val = lane % 32'h1_0000;
            if (!v.funct[2] && val >= 32'h8000) val = val - 32'h1_0000;
        end else begin
            val = v.rdat;
        end
        if ((size == 1 && off % 2 == 1) || (size == 2 && off != 0)) begin
            r.exp_mis = 1'b1; r.exp_stall = 1; r.exp_rdata = 32'h0;
        end else if (v.delay >= T) begin
            r.exp_acc = 1'b1; r.exp_stall = 1 + T; r.exp_rdata = 32'h0;
        end else if (v.err) begin
            r.exp_acc = 1'b1; r.exp_stall = 2 + v.delay; r.exp_rdata = 32'h0;
        end else begin
            r.exp_stall = 2 + v.delay;
            r.exp_rdata = (v.wr && !v.rd) ? last_rd : val;
        end
        return r;
    endfunction

    // Drive one core request; acts as bus slave answering after v.delay valid cycles
    task automatic run_txn(input vec_t v);
        int stalls = 0;
        int vcyc = 0;
        int guard = 0;
        logic exp_we;
        exp_we    = v.wr & ~v.rd;
        req_read  = v.rd;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_funct = v.funct;
        #1;
        while (stall === 1'b1 && guard < 60) begin
            stalls++;
            chk("no_err_pulse_while_stalled", {30'h0, misalign_err, access_err}, 32'h0);
            if (bus_valid === 1'b1) begin
                chk("bus_addr", bus_addr, v.addr & 32'hFFFF_FFFC);
                chk("bus_we", {31'h0, bus_we}, {31'h0, exp_we});
                if (exp_we) begin
                    chk("bus_be", {28'h0, bus_be}, {28'h0, v.exp_be});
                    chk("bus_wdata", bus_wdata, v.exp_wd);
                end
                if (vcyc == v.delay) begin
                    bus_ready = 1'b1;
                    bus_err   = v.err;
                    bus_rdata = v.rdat;
                end
                vcyc++;
            end
            @(posedge clk);
            #1;
            bus_ready = 1'b0;
            bus_err   = 1'b0;
            bus_rdata = $urandom;
            #1;
            guard++;
        end
        chk("stall_cycles", stalls, v.exp_stall);
        chk("valid_cycles", vcyc, v.exp_stall - 1);
        chk("bus_valid_dropped", {31'h0, bus_valid}, 32'h0);
        chk("rdata", rdata, v.exp_rdata);
        chk("misalign_err", {31'h0, misalign_err}, {31'h0, v.exp_mis});
        chk("access_err", {31'h0, access_err}, {31'h0, v.exp_acc});
        @(posedge clk);
        #1;
        req_read  = 1'b0;
        req_write = 1'b0;
        #1;
        chk("idle_after_txn", {29'h0, stall, misalign_err, access_err}, 32'h0);
        last_rd = v.exp_rdata;
    endtask

    initial begin
        //        rd    wr    addr          wdata         funct   d    err   rdat          exp_rdata     st mis   acc   be       wd
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_1003, 32'h1234_56AB, 3'b000, 0,   1'b0, 32'h0,        32'h0,        2, 1'b0, 1'b0, 4'b1000, 32'hABAB_ABAB};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_2002, 32'h0,         3'b000, 0,   1'b0, 32'h0080_0000, 32'hFFFF_FF80, 2, 1'b0, 1'b0, 4'b0000, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_2002, 32'h0,         3'b100, 0,   1'b0, 32'h0080_0000, 32'h0000_0080, 2, 1'b0, 1'b0, 4'b0000, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_2002, 32'h0,         3'b101, 0,   1'b0, 32'hBEEF_0000, 32'h0000_BEEF, 2, 1'b0, 1'b0, 4'b0000, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,         3'b010, 3,   1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5, 1'b0, 1'b0, 4'b0000, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_1001, 32'h0,         3'b001, 0,   1'b0, 32'h0,        32'h0,        1, 1'b1, 1'b0, 4'b0000, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_1002, 32'h0,         3'b010, 0,   1'b0, 32'h0,        32'h0,        1, 1'b1, 1'b0, 4'b0000, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         3'b010, 100, 1'b0, 32'h0,        32'h0,        5, 1'b0, 1'b1, 4'b0000, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_5000, 32'h0,         3'b010, 0,   1'b0, 32'h1122_3344, 32'h1122_3344, 2, 1'b0, 1'b0, 4'b0000, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_5004, 32'h0,         3'b010, 1,   1'b1, 32'h5555_5555, 32'h0,        3, 1'b0, 1'b1, 4'b0000, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_6000, 32'hFFFF_FFFF, 3'b010, 0,   1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 2, 1'b0, 1'b0, 4'b0000, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_5002, 32'hAAAA_CAFE, 3'b001, 2,   1'b0, 32'h0,        32'h0BAD_F00D, 4, 1'b0, 1'b0, 4'b1100, 32'hCAFE_CAFE};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_8001, 32'h0,         3'b000, 0,   1'b0, 32'h0000_7F00, 32'h0000_007F, 2, 1'b0, 1'b0, 4'b0000, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_8000, 32'h0,         3'b001, 4,   1'b0, 32'h0000_8001, 32'h0,        5, 1'b0, 1'b1, 4'b0000, 32'h0};

        // Reset state, with a request pending to show stall is gated
        req_read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", {31'h0, stall}, 32'h0);
        chk("reset_bus_valid", {31'h0, bus_valid}, 32'h0);
        chk("reset_bus_we", {31'h0, bus_we}, 32'h0);
        chk("reset_bus_addr", bus_addr, 32'h0);
        chk("reset_bus_wdata", bus_wdata, 32'h0);
        chk("reset_bus_be", {28'h0, bus_be}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_err_flags", {30'h0, misalign_err, access_err}, 32'h0);
        req_read = 1'b0;
        reset    = 1'b1;

        for (int i = 0; i < 14; i++) run_txn(vecs[i]);

        // Reset asserted in the second REQ cycle abandons the transfer
        req_read  = 1'b1;
        req_addr  = 32'h0000_7000;
        req_funct = 3'b010;
        #1;
        chk("rst_seq_accept_stall", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        chk("rst_seq_req1_valid", {31'h0, bus_valid}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_seq_stall_gated", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        req_read = 1'b0;
        chk("rst_seq_valid_dropped", {31'h0, bus_valid}, 32'h0);
        chk("rst_seq_rdata", rdata, 32'h0);
        reset = 1'b1;
        #1;
        chk("rst_seq_idle", {31'h0, stall}, 32'h0);
        last_rd = 32'h0;
        begin
            vec_t v;
            v = '{1'b1, 1'b0, 32'h0000_7004, 32'h0, 3'b010, 1, 1'b0, 32'hC0FF_EE01,
                  32'h0, 0, 1'b0, 1'b0, 4'b0000, 32'h0};
            run_txn(model(v));
        end

        // Randomized transactions against the reference model
        for (int i = 0; i < 60; i++) begin
            vec_t v;
            v.rd    = 1'($urandom_range(0, 1));
            v.wr    = v.rd ? 1'($urandom_range(0, 1)) : 1'b1;
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.funct = 3'($urandom_range(0, 7));
            v.delay = $urandom_range(0, T + 1);
            v.err   = ($urandom_range(0, 5) == 0);
            v.rdat  = $urandom;
            run_txn(model(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
